// File: rtl/if_fetch_buffer_pkg.sv
// Shared constants and helpers for the RV32I instruction-fetch stage.
// Imported by the fetch buffer, its FIFO and the bench.
package if_fetch_buffer_pkg;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;
    localparam int unsigned PC_INC    = 4;

    // Occupancy counters must be able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with full/empty flags, occupancy count and sync clear.
// The head word is read straight from registered storage.
module fetch_fifo
    import if_fetch_buffer_pkg::*;
#(
    parameter int W     = 40,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign head    = mem[rd_q];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves that cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !(rst || clr)) mem[wr_q] <= push_data;
    end

endmodule

// File: rtl/if_fetch_buffer.sv
// RV32I fetch stage: issues in-order imem requests, pairs responses with
// their PCs, buffers them for decode and discards wrong-path fetches.
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 32,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] pc_in,
    output logic               pc_en,
    input  logic               flush,
    output logic               imem_req_valid,
    output logic [A_WIDTH-1:0] imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [D_WIDTH-1:0] imem_rsp_data,
    output logic               id_valid,
    output logic [A_WIDTH-1:0] id_pc,
    output logic [D_WIDTH-1:0] id_instr,
    input  logic               id_ready
);

    localparam int CW = cnt_w(DEPTH);
    localparam int EW = A_WIDTH + D_WIDTH;

    logic [CW-1:0]      buf_cnt;
    logic [CW-1:0]      pcq_cnt;
    logic [CW-1:0]      occ;
    logic [CW-1:0]      drop_q;
    logic [CW-1:0]      drop_d;
    logic [EW-1:0]      buf_head;
    logic [A_WIDTH-1:0] pcq_head;
    logic               buf_full;
    logic               buf_empty;
    logic               pcq_full;
    logic               pcq_empty;
    logic               pop;
    logic               fire;
    logic               rsp_ok;
    logic               rsp_drop;
    logic               rsp_keep;
    logic               unused_flags;

    // Every issued request sits in the PC queue until its response
    // returns, so the queue depth is the outstanding count.
    assign occ      = buf_cnt + pcq_cnt;
    assign pop      = id_valid && id_ready;
    assign fire     = imem_req_valid && imem_req_ready;
    assign pc_en    = fire;
    assign rsp_ok   = imem_rsp_valid && (pcq_cnt != '0);
    assign rsp_drop = rsp_ok && (drop_q != '0);
    assign rsp_keep = rsp_ok && (drop_q == '0);

    assign imem_req_valid = !rst && !flush &&
                            ((occ - CW'(pop)) < CW'(DEPTH));
    assign imem_req_addr  = rst ? '0 : pc_in;

    assign id_valid = !buf_empty;
    assign id_pc    = id_valid ? buf_head[EW-1:D_WIDTH] : '0;
    assign id_instr = id_valid ? buf_head[D_WIDTH-1:0] : '0;

    assign unused_flags = ^{buf_full, pcq_full, pcq_empty};

    always_comb begin
        drop_d = drop_q;
        if (flush) begin
            drop_d = pcq_cnt - CW'(rsp_ok);
        end else if (rsp_drop) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (rsp_keep && !flush),
        .push_data ({pcq_head, imem_rsp_data}),
        .pop       (pop && !flush),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_cnt)
    );

    fetch_fifo #(
        .W     (A_WIDTH),
        .DEPTH (DEPTH)
    ) u_pcq (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .push      (fire),
        .push_data (pc_in),
        .pop       (rsp_ok),
        .head      (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_cnt)
    );

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Randomised bench for if_fetch_buffer against a queue-based fetch model,
// with directed phases pinned by hand-derived cycle expectations.
module tb_if_fetch_buffer;
    import if_fetch_buffer_pkg::*;

    localparam int A     = 8;
    localparam int D     = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [A-1:0] pc;
        bit           wrong;
    } ost_t;

    typedef struct {
        logic [A-1:0] pc;
        logic [D-1:0] data;
    } ent_t;

    typedef struct {
        int           due;
        logic [D-1:0] data;
    } mreq_t;

    logic         clk = 1'b1;
    logic         rst;
    logic [A-1:0] pc_in;
    logic         pc_en;
    logic         flush;
    logic         imem_req_valid;
    logic [A-1:0] imem_req_addr;
    logic         imem_req_ready;
    logic         imem_rsp_valid;
    logic [D-1:0] imem_rsp_data;
    logic         id_valid;
    logic [A-1:0] id_pc;
    logic [D-1:0] id_instr;
    logic         id_ready;

    if_fetch_buffer #(
        .A_WIDTH (A),
        .D_WIDTH (D),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_en          (pc_en),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    ost_t  outst[$];
    ent_t  buff[$];
    mreq_t memq[$];
    logic [A-1:0] pc_reg;
    int lat_min;
    int lat_max;
    int cyc;
    int n_cmp;
    int n_bad;
    bit cmp_en;

    bit           e_id_valid;
    logic [A-1:0] e_id_pc;
    logic [D-1:0] e_id_instr;
    bit           e_req_valid;
    bit           e_pc_en;
    logic [A-1:0] e_addr;
    bit           e_pop;

    bit           s_valid;
    logic [A-1:0] s_pc;
    bit           s_req_valid;
    bit           s_pc_en;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("id_valid", 64'(id_valid), 64'(e_id_valid));
            chk("id_pc", 64'(id_pc), 64'(e_id_pc));
            chk("id_instr", 64'(id_instr), 64'(e_id_instr));
            chk("req_valid", 64'(imem_req_valid), 64'(e_req_valid));
            chk("pc_en", 64'(pc_en), 64'(e_pc_en));
            chk("req_addr", 64'(imem_req_addr), 64'(e_addr));
        end
    end

    task automatic cycle(input bit r, input bit f, input bit idr,
                         input bit rr, input bit stray,
                         input logic [A-1:0] tgt);
        bit   mem_rsp;
        bit   got;
        ost_t o;
        mem_rsp = (memq.size() > 0) && (memq[0].due <= cyc);
        rst = r;
        flush = f;
        id_ready = idr;
        imem_req_ready = rr;
        pc_in = pc_reg;
        if (mem_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = memq[0].data;
        end else begin
            imem_rsp_valid = stray;
            imem_rsp_data = stray ? RV32I_NOP : $urandom;
        end
        e_id_valid = buff.size() > 0;
        e_id_pc = e_id_valid ? buff[0].pc : '0;
        e_id_instr = e_id_valid ? buff[0].data : '0;
        e_pop = e_id_valid && idr;
        e_req_valid = !r && !f &&
            (outst.size() + buff.size() - int'(e_pop) < DEPTH);
        e_pc_en = e_req_valid && rr;
        e_addr = r ? '0 : pc_reg;
        @(negedge clk);
        s_valid = id_valid;
        s_pc = id_pc;
        s_req_valid = imem_req_valid;
        s_pc_en = pc_en;
        @(posedge clk);
        if (r) begin
            outst.delete();
            buff.delete();
            memq.delete();
            pc_reg = '0;
        end else begin
            if (mem_rsp) void'(memq.pop_front());
            got = imem_rsp_valid && (outst.size() > 0);
            if (f) begin
                if (got) void'(outst.pop_front());
                foreach (outst[i]) outst[i].wrong = 1'b1;
                buff.delete();
                pc_reg = tgt;
            end else begin
                if (e_pop) void'(buff.pop_front());
                if (got) begin
                    o = outst.pop_front();
                    if (!o.wrong) buff.push_back('{o.pc, imem_rsp_data});
                end
                if (e_pc_en) begin
                    outst.push_back('{pc_reg, 1'b0});
                    memq.push_back('{cyc + $urandom_range(lat_max, lat_min),
                                     $urandom});
                    pc_reg = pc_reg + A'(PC_INC);
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]   en_pat;
        logic [A-1:0] tgt;
        bit           seen;
        bit           rr;
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        cmp_en = 0;
        pc_reg = '0;
        lat_min = 1;
        lat_max = 1;

        // Reset held with a stray response present.
        cycle(1, 0, 1, 1, 1, '0);
        cmp_en = 1;
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 1, 1, 1, '0);
            chk("rst_id_valid", 64'(s_valid), 64'd0);
            chk("rst_req_valid", 64'(s_req_valid), 64'd0);
            chk("rst_pc_en", 64'(s_pc_en), 64'd0);
            chk("rst_id_pc", 64'(s_pc), 64'd0);
        end

        // Streaming with a 1-cycle memory.
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 1, 1, 0, '0);
            chk("stream_pc_en", 64'(s_pc_en), 64'd1);
            chk("stream_valid", 64'(s_valid), 64'(k >= 2));
            if (k >= 2 && k <= 5)
                chk("stream_pc", 64'(s_pc), 64'((k - 2) * 4));
        end

        // Backpressure, then release.
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 1, 0, '0);
            chk("bp_req_valid", 64'(s_req_valid), 64'd0);
            chk("bp_pc_en", 64'(s_pc_en), 64'd0);
            chk("bp_valid", 64'(s_valid), 64'd1);
        end
        cycle(0, 0, 1, 1, 0, '0);
        chk("bp_resume_pc_en", 64'(s_pc_en), 64'd1);
        for (int k = 0; k < 8; k++) cycle(0, 0, 1, 1, 0, '0);

        // Flush with 8 and 12 in flight on a 3-cycle memory.
        cycle(1, 0, 1, 1, 0, '0);
        lat_min = 3;
        lat_max = 3;
        en_pat = 6'b110011;
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 1, 1, 0, '0);
            chk("fl2_pc_en", 64'(s_pc_en), 64'(en_pat[k]));
        end
        tgt = 8'h40;
        cycle(0, 1, 1, 1, 0, tgt);
        chk("fl2_flush_req", 64'(s_req_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(0, 0, 1, 1, 0, '0);
            if (i == 0) chk("fl2_post_req", 64'(s_req_valid), 64'd0);
            if (s_valid) begin
                seen = 1;
                chk("fl2_first_pc", 64'(s_pc), 64'h40);
            end
        end
        chk("fl2_seen", 64'(seen), 64'd1);

        // Flush coincident with a response and a pop.
        cycle(1, 0, 1, 1, 0, '0);
        lat_min = 1;
        lat_max = 1;
        cycle(0, 0, 1, 1, 0, '0);
        cycle(0, 0, 1, 1, 0, '0);
        tgt = 8'h80;
        cycle(0, 1, 1, 1, 0, tgt);
        chk("fl1_pop_valid", 64'(s_valid), 64'd1);
        cycle(0, 0, 1, 1, 0, '0);
        chk("fl1_next_valid", 64'(s_valid), 64'd0);
        chk("fl1_next_req", 64'(s_req_valid), 64'd1);
        cycle(0, 0, 1, 1, 0, '0);
        cycle(0, 0, 1, 1, 0, '0);
        chk("fl1_tgt_valid", 64'(s_valid), 64'd1);
        chk("fl1_tgt_pc", 64'(s_pc), 64'h80);

        // Slow memory with toggling request ready.
        cycle(1, 0, 1, 1, 0, '0);
        lat_min = 2;
        lat_max = 2;
        for (int k = 0; k < 20; k++) begin
            rr = (k % 2) == 0;
            cycle(0, 0, 1, rr, 0, '0);
            if (!rr) chk("slow_pc_en", 64'(s_pc_en), 64'd0);
        end

        // Random traffic.
        lat_min = 1;
        lat_max = 4;
        for (int k = 0; k < 3000; k++) begin
            tgt = A'($urandom) & 8'hfc;
            cycle(($urandom % 200) == 0, ($urandom % 12) == 0,
                  ($urandom % 4) != 0, ($urandom % 3) != 0,
                  ($urandom % 20) == 0, tgt);
        end

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
